bus_demux32: RTL and testbench
==============================

Name: bus_demux32

Overview:
- Routes one CPU data-memory request to one of two 32-bit targets: low = data RAM, high = MMIO peripherals.
- The target is decoded from the request address.
- Read data from the selected target is merged back into a single response.
- Sits between the MEM stage and the memory/peripheral buses; one outstanding transaction; registered outputs.

Parameters:
- MMIO_BASE, 32'hFFFF_0000, address compare value selecting the high target.
- MMIO_MASK, 32'hFFFF_0000, address bits participating in the compare.
- TIMEOUT_CYCLES, 255, read-response wait limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables.
- l_valid / h_valid  out  1  request to low / high target.
- l_ready / h_ready  in  1  target accepts the request.
- l_addr, l_wdata / h_addr, h_wdata  out  32  forwarded address and data.
- l_we, l_be / h_we, h_be  out  1, 4  forwarded write enable and byte enables.
- l_rvalid / h_rvalid  in  1  read data valid from target.
- l_rdata / h_rdata  in  32  read data from target.
- rsp_valid  out  1  one-cycle read-response strobe.
- rsp_rdata  out  32  read response data.
- rsp_err  out  1  response was a timeout (always 0 without the feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, req_ready=1.
  - l_valid=h_valid=0, rsp_valid=0, rsp_err=0.
  - Address, data and enable outputs = 0; rsp_rdata=0.
  - Reset mid-transaction aborts it; no response is issued.
- Decode: sel_h = ((req_addr & MMIO_MASK) == MMIO_BASE). Decoded at acceptance and latched.
- FSM states: IDLE, SEND, WAIT_RSP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata/we/be/sel_h, go to SEND.
  - In cycle N+1, the selected *_valid is 1 and the other target's valid stays 0.
- SEND:
  - The selected *_valid and payload are held stable until that target's *_ready is 1.
  - On handshake with a write: return to IDLE; no response strobe.
  - On handshake with a read: go to WAIT_RSP.
  - If the selected *_rvalid is 1 in the same handshake cycle: capture data and go directly to RESP.
- WAIT_RSP:
  - *_valid=0.
  - On the selected target's *_rvalid: capture its rdata, go to RESP.
  - rvalid from the non-selected target is ignored in every state.
- RESP:
  - rsp_valid=1 and rsp_rdata=captured data for exactly one cycle, then IDLE.
  - req_ready=0 in this state.
- Latency:
  - Write: accept at edge N, target valid from N+1, req_ready back 1 cycle after the target handshake.
  - Read: rsp_valid 1 cycle after rvalid is sampled.
- req_ready=0 in SEND, WAIT_RSP and RESP; req_valid is ignored there.
- rsp_rdata holds its last value between responses.

Optional Feature:
- Macro BUS_DEMUX32_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in WAIT_RSP and clears on entry.
  - When the count reaches TIMEOUT_CYCLES with no rvalid: go to RESP with rsp_rdata=32'hDEAD_BEEF and rsp_err=1 for that cycle.
  - An rvalid arriving on the same cycle as the timeout wins; rsp_err=0.
- Disabled: no counter; WAIT_RSP waits indefinitely; rsp_err is tied 0.

Decomposition:
- Package bus_demux32_pkg holds:
  - the state enum (IDLE/SEND/WAIT_RSP/RESP);
  - default MMIO_BASE and MMIO_MASK;
  - TIMEOUT_DATA = 32'hDEAD_BEEF.
- One natural sub-module, rsp_timer: the load/clear/expire counter, instantiated only under BUS_DEMUX32_TIMEOUT_EN.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> req_ready=1, all valids=0, rsp_valid=0, rsp_rdata=0.
- RAM write: addr=32'h0000_1000, we=1, wdata=32'h1234_5678, l_ready delayed 3 cycles ->
  - l_valid held 3 cycles with stable payload;
  - h_valid never asserts;
  - no rsp_valid;
  - req_ready=1 one cycle after the handshake.
- MMIO read: addr=32'hFFFF_0004, we=0, h_ready=1 immediately, h_rvalid after 2 cycles with 32'hCAFE_F00D ->
  - one rsp_valid pulse with rsp_rdata=32'hCAFE_F00D;
  - a spurious l_rvalid injected in the same window is ignored.
- Same-cycle read: l_ready=1 and l_rvalid=1 with l_rdata=32'h0000_00AA in the handshake cycle -> rsp_valid the next cycle with 32'h0000_00AA.
- Reset mid-read: rst_n=0 while in WAIT_RSP -> immediate IDLE outputs; a later l_rvalid produces no rsp_valid.
- With BUS_DEMUX32_TIMEOUT_EN and TIMEOUT_CYCLES=4: read with no rvalid -> rsp_valid with rsp_rdata=32'hDEAD_BEEF and rsp_err=1 after 4 WAIT_RSP cycles. Repeat with rvalid on the 4th cycle -> real data returned, rsp_err=0.

Source files
------------

// File: rtl/bus_demux32_pkg.sv
// Shared types and constants for the bus_demux32 request router.
// Optional response timeout is built only with BUS_DEMUX32_TIMEOUT_EN.
package bus_demux32_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;

  function automatic logic is_mmio(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_demux32_rsp_timer.sv
// Read-response watchdog: down-counter loaded on entry to the wait state,
// flagging expiry on the last allowed wait cycle.
module bus_demux32_rsp_timer
  import bus_demux32_pkg::*;
#(
  parameter int unsigned CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q;

  // Loaded with CYCLES-1 so terminal count lands on the CYCLES-th wait cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(CYCLES - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/bus_demux32.sv
// Two-target data-memory demux: low = data RAM, high = MMIO, one outstanding
// transaction. Define BUS_DEMUX32_TIMEOUT_EN to add the read-response timeout.
module bus_demux32
  import bus_demux32_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_MASK      = MMIO_MASK_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  output logic        l_valid_o,
  input  logic        l_ready_i,
  output logic [31:0] l_addr_o,
  output logic [31:0] l_wdata_o,
  output logic        l_we_o,
  output logic [3:0]  l_be_o,
  input  logic        l_rvalid_i,
  input  logic [31:0] l_rdata_i,
  output logic        h_valid_o,
  input  logic        h_ready_i,
  output logic [31:0] h_addr_o,
  output logic [31:0] h_wdata_o,
  output logic        h_we_o,
  output logic [3:0]  h_be_o,
  input  logic        h_rvalid_i,
  input  logic [31:0] h_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q, sel_h_q;
  logic        l_valid_q, h_valid_q, req_ready_q, rsp_valid_q, rsp_err_q;

  logic        sel_h_d;
  logic        tgt_ready, tgt_rvalid;
  logic [31:0] tgt_rdata;
  logic        timeout_hit;

  assign sel_h_d = is_mmio(req_addr_i, MMIO_BASE, MMIO_MASK);

  // The non-selected target's handshake and read strobes never reach the FSM.
  always_comb begin
    tgt_ready  = sel_h_q ? h_ready_i  : l_ready_i;
    tgt_rvalid = sel_h_q ? h_rvalid_i : l_rvalid_i;
    tgt_rdata  = sel_h_q ? h_rdata_i  : l_rdata_i;
  end

`ifdef BUS_DEMUX32_TIMEOUT_EN
  bus_demux32_rsp_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    ((state_q == SEND) && tgt_ready && !we_q),
    .run_i     (state_q == WAIT_RSP),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      sel_h_q     <= 1'b0;
      l_valid_q   <= 1'b0;
      h_valid_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            we_q        <= req_we_i;
            be_q        <= req_be_i;
            sel_h_q     <= sel_h_d;
            l_valid_q   <= !sel_h_d;
            h_valid_q   <= sel_h_d;
            req_ready_q <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (tgt_ready) begin
            l_valid_q <= 1'b0;
            h_valid_q <= 1'b0;
            if (we_q) begin
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else if (tgt_rvalid) begin
              rdata_q     <= tgt_rdata;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // Real data beats a timeout that expires in the same cycle.
          if (tgt_rvalid) begin
            rdata_q     <= tgt_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rdata_q     <= TIMEOUT_DATA;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign l_valid_o   = l_valid_q;
  assign h_valid_o   = h_valid_q;
  assign l_addr_o    = addr_q;
  assign l_wdata_o   = wdata_q;
  assign l_we_o      = we_q;
  assign l_be_o      = be_q;
  assign h_addr_o    = addr_q;
  assign h_wdata_o   = wdata_q;
  assign h_we_o      = we_q;
  assign h_be_o      = be_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_bus_demux32.sv
// Directed bench for bus_demux32; timeout scenarios run when
// BUS_DEMUX32_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_bus_demux32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        l_valid, l_ready, l_we, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic [3:0]  l_be;
  logic        h_valid, h_ready, h_we, h_rvalid;
  logic [31:0] h_addr, h_wdata, h_rdata;
  logic [3:0]  h_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_demux32 #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .req_be_i(req_be),
    .l_valid_o(l_valid), .l_ready_i(l_ready), .l_addr_o(l_addr), .l_wdata_o(l_wdata),
    .l_we_o(l_we), .l_be_o(l_be), .l_rvalid_i(l_rvalid), .l_rdata_i(l_rdata),
    .h_valid_o(h_valid), .h_ready_i(h_ready), .h_addr_o(h_addr), .h_wdata_o(h_wdata),
    .h_we_o(h_we), .h_be_o(h_be), .h_rvalid_i(h_rvalid), .h_rdata_i(h_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    l_ready = 0; l_rvalid = 0; l_rdata = '0;
    h_ready = 0; h_rvalid = 0; h_rdata = '0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1; req_addr = addr; req_we = we; req_wdata = wdata; req_be = be;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_be = 4'($urandom); l_ready = 1'($urandom); h_ready = 1'($urandom);
      l_rvalid = 1'($urandom); h_rvalid = 1'($urandom); l_rdata = $urandom; h_rdata = $urandom;
      tick();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_checks++; if ({l_valid, h_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids got %b exp 00", {l_valid, h_valid}); end
      n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got v=%b e=%b exp 0 0", rsp_valid, rsp_err); end
      n_checks++; if (rsp_rdata !== 32'h0 || l_addr !== 32'h0 || h_wdata !== 32'h0 || l_be !== 4'h0) begin
        n_fail++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h be=%h exp 0", rsp_rdata, l_addr, h_wdata, l_be); end
    end
    clear_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_ram_write();
    issue(32'h0000_1000, 1'b1, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_be = 4'h0;
      end
      n_checks++; if (l_valid !== 1'b1 || h_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid[%0d] got l=%b h=%b exp 1 0", i, l_valid, h_valid); end
      n_checks++; if (l_addr !== 32'h0000_1000 || l_wdata !== 32'h1234_5678 || l_we !== 1'b1 || l_be !== 4'hF) begin
        n_fail++; $display("FAIL wr_payload[%0d] got %h %h %b %h exp 00001000 12345678 1 f", i, l_addr, l_wdata, l_we, l_be); end
      n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_busy[%0d] got rdy=%b rsp=%b exp 0 0", i, req_ready, rsp_valid); end
      if (i == 2) l_ready = 1;
    end
    tick();
    l_ready = 0;
    n_checks++; if (l_valid !== 1'b0 || h_valid !== 1'b0) begin n_fail++; $display("FAIL wr_done_valid got l=%b h=%b exp 0 0", l_valid, h_valid); end
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_done got rdy=%b rsp=%b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_mmio_read();
    issue(32'hFFFF_0004, 1'b0, 32'h0, 4'hF);
    h_ready = 1;
    tick();
    req_valid = 0;
    n_checks++; if (h_valid !== 1'b1 || l_valid !== 1'b0 || h_addr !== 32'hFFFF_0004 || h_we !== 1'b0) begin
      n_fail++; $display("FAIL rd_send got h=%b l=%b addr=%h we=%b exp 1 0 ffff0004 0", h_valid, l_valid, h_addr, h_we); end
    tick();
    h_ready = 0;
    l_rvalid = 1; l_rdata = 32'h1111_1111;
    n_checks++; if (h_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rd_wait got h=%b rsp=%b rdy=%b exp 0 0 0", h_valid, rsp_valid, req_ready); end
    tick();
    l_rvalid = 0;
    h_rvalid = 1; h_rdata = 32'hCAFE_F00D;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_spurious got rsp=%b exp 0", rsp_valid); end
    tick();
    h_rvalid = 0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp got v=%b d=%h e=%b rdy=%b exp 1 cafef00d 0 0", rsp_valid, rsp_rdata, rsp_err, req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL rd_after got v=%b rdy=%b d=%h exp 0 1 cafef00d", rsp_valid, req_ready, rsp_rdata); end
  endtask

  task automatic test_same_cycle_read();
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h3);
    tick();
    req_valid = 0;
    l_ready = 1; l_rvalid = 1; l_rdata = 32'h0000_00AA;
    tick();
    clear_inputs();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00AA || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle got v=%b d=%h e=%b exp 1 000000aa 0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_end got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    issue(32'hFFFF_8000, 1'b1, 32'hA5A5_5A5A, 4'h1);
    h_ready = 1;
    tick();
    req_addr = 32'h0000_0100;
    n_checks++; if (h_valid !== 1'b1 || l_valid !== 1'b0 || h_wdata !== 32'hA5A5_5A5A || h_be !== 4'h1) begin
      n_fail++; $display("FAIL b2b_hwrite got h=%b l=%b d=%h be=%h exp 1 0 a5a55a5a 1", h_valid, l_valid, h_wdata, h_be); end
    tick();
    h_ready = 0;
    n_checks++; if (h_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got h=%b rdy=%b rsp=%b exp 0 1 0", h_valid, req_ready, rsp_valid); end
    tick();
    req_valid = 0;
    n_checks++; if (l_valid !== 1'b1 || h_valid !== 1'b0 || l_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL b2b_second got l=%b h=%b addr=%h exp 1 0 00000100", l_valid, h_valid, l_addr); end
    l_ready = 1;
    tick();
    l_ready = 0;
  endtask

  task automatic test_reset_mid_read();
    issue(32'h0000_2000, 1'b0, 32'h0, 4'hF);
    l_ready = 1;
    tick();
    req_valid = 0;
    tick();
    l_ready = 0;
    n_checks++; if (l_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_wait got l=%b rdy=%b exp 0 0", l_valid, req_ready); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (req_ready !== 1'b1 || l_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || l_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset got rdy=%b l=%b v=%b d=%h a=%h exp 1 0 0 0 0", req_ready, l_valid, rsp_valid, rsp_rdata, l_addr); end
    #2 rst_n = 1;
    l_rvalid = 1; l_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0 || l_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after[%0d] got v=%b l=%b exp 0 0", i, rsp_valid, l_valid); end
    end
    clear_inputs();
    tick();
  endtask

`ifdef BUS_DEMUX32_TIMEOUT_EN
  task automatic test_timeout(input logic late_rvalid);
    issue(32'h0000_3000, 1'b0, 32'h0, 4'hF);
    l_ready = 1;
    tick();
    req_valid = 0;
    tick();
    l_ready = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d] got v=%b exp 0", i, rsp_valid); end
      if (i == 3 && late_rvalid) begin l_rvalid = 1; l_rdata = 32'h0BAD_F00D; end
      tick();
    end
    l_rvalid = 0;
    if (late_rvalid) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL to_race got v=%b d=%h e=%b exp 1 0badf00d 0", rsp_valid, rsp_rdata, rsp_err); end
    end else begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1) begin
        n_fail++; $display("FAIL to_expire got v=%b d=%h e=%b exp 1 deadbeef 1", rsp_valid, rsp_rdata, rsp_err); end
    end
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_end got v=%b e=%b rdy=%b exp 0 0 1", rsp_valid, rsp_err, req_ready); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 0;
    tick();
    test_reset();
    test_ram_write();
    test_mmio_read();
    test_same_cycle_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef BUS_DEMUX32_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
